// File: rtl/fg_dac_pkg.sv
// Shared FSM encodings, default frame constants and offset-binary helper for the DAC SPI sink.
// Latency: n/a (package only).
// Backpressure: n/a.
package fg_dac_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_LDAC  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int         FRAME_BITS_DEF = 24;
    localparam logic [7:0] CMD_WORD_DEF   = 8'h30;

    // Two's complement to offset binary is just an inversion of the sign bit.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] s, input int unsigned bw);
        return s ^ (32'd1 << (bw - 1));
    endfunction

endpackage

// File: rtl/fg_dac_spi_tx_if.sv
// Sample handshake between the limiter and the DAC SPI sink.
// Latency: n/a (wires only).
// Backpressure: sample held by master until sample_valid & sample_ready.
interface fg_dac_spi_tx_if #(
    parameter int BITWIDTH = 16
);
    logic signed [BITWIDTH-1:0] sample;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (output sample, output sample_valid, input  sample_ready);
    modport slave  (input  sample, input  sample_valid, output sample_ready);
endinterface

// File: rtl/fg_sclk_gen.sv
// SPI clock generator: CLK_DIV-cycle half periods, sclk starts low, with one-cycle rise/fall strobes.
// Latency: sclk low for CLK_DIV cycles after start, strobes are combinational from the counter.
// Backpressure: none; start/stop are synchronous and stop forces sclk low.
module fg_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic start,
    input  logic stop,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             run;
    logic             half_done;

    // Strobes flag the cycle whose closing edge toggles sclk.
    assign half_done = run && (div_cnt == DIV_LAST);
    assign sclk_rise = half_done && !sclk;
    assign sclk_fall = half_done && sclk;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            run     <= 1'b0;
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (start) begin
            run     <= 1'b1;
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (stop) begin
            run     <= 1'b0;
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run) begin
            if (half_done) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/fg_dac_spi_tx.sv
// Offset-binary SPI DAC sink (mode 0, MSB first, command field first); FG_DAC_LDAC_EN adds an LDAC pulse.
// Latency: cs_n low the cycle after acceptance; next acceptance 1+2*CLK_DIV*FRAME_BITS+2*CLK_DIV cycles later (+CLK_DIV with LDAC).
// Backpressure: sample_ready only in IDLE with enable_i high; upstream holds the sample until accepted.
module fg_dac_spi_tx
    import fg_dac_pkg::*;
#(
    parameter int          BITWIDTH   = 16,
    parameter int          FRAME_BITS = FRAME_BITS_DEF,
    parameter logic [31:0] CMD_WORD   = 32'(CMD_WORD_DEF),
    parameter int          CLK_DIV    = 2
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              enable_i,
    fg_dac_spi_tx_if.slave    smp,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o
`ifdef FG_DAC_LDAC_EN
    ,
    output logic              ldac_n_o
`endif
);
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] PH_LAST  = DIV_W'(CLK_DIV - 1);
    // Command sits above the sample; it vanishes entirely when FRAME_BITS == BITWIDTH.
    localparam logic [FRAME_BITS-1:0] CMD_FIELD = FRAME_BITS'(64'(CMD_WORD) << BITWIDTH);

    logic [2:0]            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_init;
    logic [BITWIDTH-1:0]   ob_sample;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      ph_cnt;
    logic                  accept;
    logic                  last_bit;
    logic                  ph_last;
    logic                  sclk;
    logic                  sclk_fall;
    logic                  sclk_rise_unused;

    assign ob_sample  = BITWIDTH'(to_offset_bin(32'(smp.sample), BITWIDTH));
    assign frame_init = CMD_FIELD | FRAME_BITS'(ob_sample);

    assign smp.sample_ready = nrst_i && enable_i && (state == ST_IDLE);
    assign accept           = smp.sample_valid && smp.sample_ready;
    assign last_bit         = sclk_fall && (bit_cnt == BIT_LAST);
    assign ph_last          = (ph_cnt == PH_LAST);

    fg_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .start     (accept),
        .stop      ((state == ST_SHIFT) && last_bit),
        .sclk      (sclk),
        .sclk_rise (sclk_rise_unused),
        .sclk_fall (sclk_fall)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ph_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_SHIFT;
                        shreg   <= frame_init;
                        bit_cnt <= '0;
                        ph_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Data moves on the falling edge so it is stable around the DAC's rising-edge sample.
                    if (sclk_fall) begin
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                        if (last_bit) begin
                            state  <= ST_HOLD;
                            ph_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (ph_last) begin
                        ph_cnt <= '0;
`ifdef FG_DAC_LDAC_EN
                        state  <= ST_LDAC;
`else
                        state  <= ST_GAP;
`endif
                    end else begin
                        ph_cnt <= ph_cnt + DIV_W'(1);
                    end
                end
`ifdef FG_DAC_LDAC_EN
                ST_LDAC: begin
                    if (ph_last) begin
                        ph_cnt <= '0;
                        state  <= ST_GAP;
                    end else begin
                        ph_cnt <= ph_cnt + DIV_W'(1);
                    end
                end
`endif
                ST_GAP: begin
                    if (ph_last) begin
                        ph_cnt <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign sclk_o = sclk;
    assign cs_n_o = !((state == ST_SHIFT) || (state == ST_HOLD));
    assign mosi_o = (state == ST_SHIFT) && shreg[FRAME_BITS-1];
`ifdef FG_DAC_LDAC_EN
    assign ldac_n_o = (state != ST_LDAC);
`endif

endmodule
